// File: rtl/fb_burst_responder_pkg.sv
// ---------------------------------------------------------------------------
// fb_mem_pkg
// Shared constants and types for the framebuffer read responder.
//   FB_BASE_HI      : expected value of addr[23:20] for a framebuffer access
//   BURST_DEFAULT   : default number of words returned per accepted request
//   fb_resp_state_t : responder FSM state encoding
// ---------------------------------------------------------------------------
package fb_mem_pkg;

    localparam logic [3:0] FB_BASE_HI    = 4'hf;
    localparam int         BURST_DEFAULT = 4;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } fb_resp_state_t;

endpackage : fb_mem_pkg

// File: rtl/fb_burst_responder_if.sv
// ---------------------------------------------------------------------------
// fb_burst_responder_if
// Request/response bundle between the TFT pixel fetcher (master) and the
// framebuffer responder (slave).
//   req      : master wants one burst (may stay high across bursts)
//   rdy      : slave can accept
//   addr     : burst start address, sampled only on accept
//   data     : returned word, valid while ifrdy is high, held until next ifrdy
//   ifrdy    : one-cycle strobe per returned word
//   busy     : accept through last ifrdy, inclusive
//   bad_addr : sticky out-of-framebuffer address flag
//
// Handshake: a burst is accepted in every cycle where req & rdy is high.
// rdy depends only on responder state, never on req, so the requester may
// derive req from rdy without creating a combinational loop. Once accepted,
// a burst always completes and produces exactly BURST ifrdy strobes; there is
// no back-pressure on the returned words.
// ---------------------------------------------------------------------------
interface fb_burst_responder_if;

    logic        req;
    logic        rdy;
    logic [23:0] addr;
    logic [15:0] data;
    logic        ifrdy;
    logic        busy;
    logic        bad_addr;

    modport master (
        output req,
        output addr,
        input  rdy,
        input  data,
        input  ifrdy,
        input  busy,
        input  bad_addr
    );

    modport slave (
        input  req,
        input  addr,
        output rdy,
        output data,
        output ifrdy,
        output busy,
        output bad_addr
    );

endinterface : fb_burst_responder_if

// File: rtl/fb_burst_responder.sv
// ---------------------------------------------------------------------------
// fb_burst_responder
// Memory-side responder for the TFT framebuffer read port. Each accepted
// request reads BURST consecutive 16-bit words from an asynchronous SRAM,
// starting at the BURST-aligned address, and returns them one strobe each.
// Every word access lasts WAIT+1 cycles.
//
// Ports:
//   clkSYS     : system clock
//   n_reset    : asynchronous active-low reset
//   fb         : request/response bundle (slave side)
//   sram_addr  : SRAM word address (0 while idle)
//   sram_dq    : SRAM read data
//   sram_ce_n  : SRAM chip enable, active low
//   sram_oe_n  : SRAM output enable, active low
//   dbg_state  : current FSM state, for observation only
//
// Parameters: BURST (power of two, 2..16), WAIT (0..15), AW (SRAM address bits)
// ---------------------------------------------------------------------------
module fb_burst_responder
    import fb_mem_pkg::*;
#(
    parameter int BURST = BURST_DEFAULT,
    parameter int WAIT  = 1,
    parameter int AW    = 20
) (
    input  logic           clkSYS,
    input  logic           n_reset,
    fb_burst_responder_if.slave fb,
    output logic [AW-1:0]  sram_addr,
    input  logic [15:0]    sram_dq,
    output logic           sram_ce_n,
    output logic           sram_oe_n,
    output fb_resp_state_t dbg_state
);

    localparam int IW = $clog2(BURST);  // word index width inside a burst
    localparam int WW = 4;              // wait counter width, covers WAIT up to 15

    fb_resp_state_t  state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [WW-1:0]   wc_q, wc_d;
    logic [AW-IW-1:0] base_q, base_d;   // aligned base, low IW bits implied zero
    logic [15:0]     data_q, data_d;
    logic            ifrdy_q, ifrdy_d;
    logic            bad_q, bad_d;

    logic accept;
    logic word_done;
    logic last_word;

    assign accept    = fb.req && (state_q == IDLE);
    assign word_done = (state_q == ACCESS) && (wc_q == WW'(WAIT));
    assign last_word = (idx_q == IW'(BURST - 1));

    // State register and datapath registers
    always_ff @(posedge clkSYS or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            wc_q    <= '0;
            base_q  <= '0;
            data_q  <= '0;
            ifrdy_q <= 1'b0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wc_q    <= wc_d;
            base_q  <= base_d;
            data_q  <= data_d;
            ifrdy_q <= ifrdy_d;
            bad_q   <= bad_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ACCESS;
            ACCESS:  if (word_done && last_word) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Word timer and capture path. The capture on the last word and the
    // transition to IDLE happen on the same edge, so the last strobe lands in
    // the first IDLE cycle and a new request can be accepted right there.
    always_comb begin
        idx_d   = idx_q;
        wc_d    = wc_q;
        base_d  = base_q;
        data_d  = data_q;
        ifrdy_d = 1'b0;
        bad_d   = bad_q;
        if (accept) begin
            idx_d  = '0;
            wc_d   = '0;
            base_d = fb.addr[AW-1:IW];
            if (fb.addr[23:20] != FB_BASE_HI) bad_d = 1'b1;
        end else if (state_q == ACCESS) begin
            if (word_done) begin
                wc_d    = '0;
                idx_d   = idx_q + 1'b1;
                data_d  = sram_dq;
                ifrdy_d = 1'b1;
            end else begin
                wc_d = wc_q + 1'b1;
            end
        end
    end

    // Outputs. The base is aligned, so concatenating the index is base + idx.
    always_comb begin
        fb.rdy    = (state_q == IDLE);
        sram_ce_n = (state_q != ACCESS);
        sram_oe_n = (state_q != ACCESS);
        sram_addr = (state_q == ACCESS) ? {base_q, idx_q} : '0;
    end

    assign fb.data     = data_q;
    assign fb.ifrdy    = ifrdy_q;
    assign fb.busy     = accept || (state_q == ACCESS) || ifrdy_q;
    assign fb.bad_addr = bad_q;
    assign dbg_state   = state_q;

endmodule : fb_burst_responder

// File: tb/tb_fb_burst_responder.sv
// ---------------------------------------------------------------------------
// tb_fb_burst_responder
// Two responders share one clock: u1 with WAIT=1 and u0 with WAIT=0, each
// with its own reset and an SRAM model that returns the low 16 address bits.
// ---------------------------------------------------------------------------
module tb_fb_burst_responder;
    import fb_mem_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic n_reset1;
    logic n_reset0;

    fb_burst_responder_if if1();
    fb_burst_responder_if if0();

    logic [19:0]    sa1, sa0;
    logic [15:0]    dq1, dq0;
    logic           ce1, oe1, ce0, oe0;
    fb_resp_state_t st1, st0;

    assign dq1 = sa1[15:0];
    assign dq0 = sa0[15:0];

    fb_burst_responder #(.BURST(4), .WAIT(1), .AW(20)) u1 (
        .clkSYS(clk), .n_reset(n_reset1), .fb(if1),
        .sram_addr(sa1), .sram_dq(dq1), .sram_ce_n(ce1), .sram_oe_n(oe1),
        .dbg_state(st1)
    );

    fb_burst_responder #(.BURST(4), .WAIT(0), .AW(20)) u0 (
        .clkSYS(clk), .n_reset(n_reset0), .fb(if0),
        .sram_addr(sa0), .sram_dq(dq0), .sram_ce_n(ce0), .sram_oe_n(oe0),
        .dbg_state(st0)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int          unit;
        logic        req;
        logic [23:0] addr;
        logic        exp_ifrdy;
        logic [15:0] exp_data;
        logic        exp_busy;
        logic        exp_rdy;
        logic        exp_ce_n;
        logic [19:0] exp_sa;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int unit, input logic req, input logic [23:0] addr,
                       input logic ifrdy, input logic [15:0] data, input logic busy,
                       input logic rdy, input logic ce_n, input logic [19:0] sa);
        vec_t v;
        v.unit = unit; v.req = req; v.addr = addr; v.exp_ifrdy = ifrdy;
        v.exp_data = data; v.exp_busy = busy; v.exp_rdy = rdy;
        v.exp_ce_n = ce_n; v.exp_sa = sa;
        vecs.push_back(v);
    endtask

    // ---------------- driver tasks ----------------
    // Issue a one-cycle request on u0 and score every returned word.
    task automatic burst0(input logic [23:0] addr);
        logic [19:0] base;
        base = {addr[19:2], 2'b00};
        for (int k = 0; k < 4; k++) exp_q.push_back(16'(base + 20'(k)));
        @(posedge clk); #1;
        if0.req = 1'b1; if0.addr = addr;
        @(posedge clk); #1;
        if0.req = 1'b0; if0.addr = 24'h0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (if0.ifrdy === 1'b1) begin
                if (exp_q.size() == 0) chk("u0_extra_strobe", 32'(if0.data), 32'hffff_ffff);
                else chk("u0_burst_word", 32'(if0.data), 32'(exp_q.pop_front()));
            end
            @(posedge clk); #1;
        end
        chk("u0_words_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    int strobes;

    initial begin
        if1.req = 1'b0; if1.addr = '0;
        if0.req = 1'b0; if0.addr = '0;
        n_reset1 = 1'b0;
        n_reset0 = 1'b0;

        // Tests 1+2: u1, WAIT=1, req held high, second burst at +4
        add(1, 1, 24'hF00010, 0, 16'h0000, 1, 1, 1, 20'h00);  // c0 accept
        add(1, 1, 24'hF00010, 0, 16'h0000, 1, 0, 0, 20'h10);
        add(1, 1, 24'hF00010, 0, 16'h0000, 1, 0, 0, 20'h10);
        add(1, 1, 24'hF00010, 1, 16'h0010, 1, 0, 0, 20'h11);  // c3
        add(1, 1, 24'hF00010, 0, 16'h0010, 1, 0, 0, 20'h11);
        add(1, 1, 24'hF00010, 1, 16'h0011, 1, 0, 0, 20'h12);  // c5
        add(1, 1, 24'hF00010, 0, 16'h0011, 1, 0, 0, 20'h12);
        add(1, 1, 24'hF00010, 1, 16'h0012, 1, 0, 0, 20'h13);  // c7
        add(1, 1, 24'hF00010, 0, 16'h0012, 1, 0, 0, 20'h13);
        add(1, 1, 24'hF00014, 1, 16'h0013, 1, 1, 1, 20'h00);  // c9 last + accept
        add(1, 0, 24'h000000, 0, 16'h0013, 1, 0, 0, 20'h14);
        add(1, 0, 24'h000000, 0, 16'h0013, 1, 0, 0, 20'h14);
        add(1, 0, 24'h000000, 1, 16'h0014, 1, 0, 0, 20'h15);  // c12
        add(1, 0, 24'h000000, 0, 16'h0014, 1, 0, 0, 20'h15);
        add(1, 0, 24'h000000, 1, 16'h0015, 1, 0, 0, 20'h16);  // c14
        add(1, 0, 24'h000000, 0, 16'h0015, 1, 0, 0, 20'h16);
        add(1, 0, 24'h000000, 1, 16'h0016, 1, 0, 0, 20'h17);  // c16
        add(1, 0, 24'h000000, 0, 16'h0016, 1, 0, 0, 20'h17);
        add(1, 0, 24'h000000, 1, 16'h0017, 1, 1, 1, 20'h00);  // c18
        add(1, 0, 24'h000000, 0, 16'h0017, 0, 1, 1, 20'h00);
        // Test 3/6: u0, WAIT=0, unaligned addr, req pulsed for one cycle
        add(0, 1, 24'hF00006, 0, 16'h0000, 1, 1, 1, 20'h0);
        add(0, 0, 24'h000000, 0, 16'h0000, 1, 0, 0, 20'h4);
        add(0, 0, 24'h000000, 1, 16'h0004, 1, 0, 0, 20'h5);
        add(0, 0, 24'h000000, 1, 16'h0005, 1, 0, 0, 20'h6);
        add(0, 0, 24'h000000, 1, 16'h0006, 1, 0, 0, 20'h7);
        add(0, 0, 24'h000000, 1, 16'h0007, 1, 1, 1, 20'h0);
        add(0, 0, 24'h000000, 0, 16'h0007, 0, 1, 1, 20'h0);

        // Reset values, sampled while reset is still asserted
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rdy",      32'(if1.rdy), 32'd1);
        chk("rst_ifrdy",    32'(if1.ifrdy), 32'd0);
        chk("rst_data",     32'(if1.data), 32'd0);
        chk("rst_busy",     32'(if1.busy), 32'd0);
        chk("rst_bad_addr", 32'(if1.bad_addr), 32'd0);
        chk("rst_ce_n",     32'(ce1), 32'd1);
        chk("rst_oe_n",     32'(oe1), 32'd1);
        chk("rst_sram_addr", 32'(sa1), 32'd0);
        @(posedge clk); #1;
        n_reset1 = 1'b1;
        n_reset0 = 1'b1;

        // Table-driven cycles
        strobes = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk); #1;
            if (vecs[i].unit == 1) begin
                if1.req = vecs[i].req; if1.addr = vecs[i].addr;
                if0.req = 1'b0;
            end else begin
                if0.req = vecs[i].req; if0.addr = vecs[i].addr;
                if1.req = 1'b0;
            end
            @(negedge clk);
            if (vecs[i].unit == 1) begin
                if (if1.ifrdy === 1'b1) strobes++;
                chk($sformatf("v%0d_ifrdy", i), 32'(if1.ifrdy), 32'(vecs[i].exp_ifrdy));
                chk($sformatf("v%0d_data", i),  32'(if1.data),  32'(vecs[i].exp_data));
                chk($sformatf("v%0d_busy", i),  32'(if1.busy),  32'(vecs[i].exp_busy));
                chk($sformatf("v%0d_rdy", i),   32'(if1.rdy),   32'(vecs[i].exp_rdy));
                chk($sformatf("v%0d_ce_n", i),  32'(ce1),       32'(vecs[i].exp_ce_n));
                chk($sformatf("v%0d_oe_n", i),  32'(oe1),       32'(vecs[i].exp_ce_n));
                chk($sformatf("v%0d_sa", i),    32'(sa1),       32'(vecs[i].exp_sa));
                chk($sformatf("v%0d_bad", i),   32'(if1.bad_addr), 32'd0);
            end else begin
                chk($sformatf("v%0d_ifrdy", i), 32'(if0.ifrdy), 32'(vecs[i].exp_ifrdy));
                chk($sformatf("v%0d_data", i),  32'(if0.data),  32'(vecs[i].exp_data));
                chk($sformatf("v%0d_busy", i),  32'(if0.busy),  32'(vecs[i].exp_busy));
                chk($sformatf("v%0d_rdy", i),   32'(if0.rdy),   32'(vecs[i].exp_rdy));
                chk($sformatf("v%0d_ce_n", i),  32'(ce0),       32'(vecs[i].exp_ce_n));
                chk($sformatf("v%0d_sa", i),    32'(sa0),       32'(vecs[i].exp_sa));
            end
        end
        chk("u1_total_strobes", 32'(strobes), 32'd8);
        chk("u0_bad_before", 32'(if0.bad_addr), 32'd0);

        // Test 4: out-of-range address still served, flag sticky
        burst0(24'h300000);
        chk("u0_bad_set", 32'(if0.bad_addr), 32'd1);
        burst0(24'hF00020);
        chk("u0_bad_sticky", 32'(if0.bad_addr), 32'd1);

        // Test 5: reset u1 in cycle 5 of a WAIT=1 burst
        @(posedge clk); #1;
        if1.req = 1'b1; if1.addr = 24'hF00010;        // c0
        @(posedge clk); #1;
        if1.req = 1'b0;                               // c1
        repeat (4) @(posedge clk);
        #1;                                           // c5
        chk("mid_ifrdy_before", 32'(if1.ifrdy), 32'd1);
        chk("mid_data_before",  32'(if1.data), 32'h0011);
        n_reset1 = 1'b0;
        #1;
        chk("mid_rst_ifrdy", 32'(if1.ifrdy), 32'd0);
        chk("mid_rst_data",  32'(if1.data), 32'd0);
        chk("mid_rst_ce_n",  32'(ce1), 32'd1);
        chk("mid_rst_oe_n",  32'(oe1), 32'd1);
        chk("mid_rst_rdy",   32'(if1.rdy), 32'd1);
        chk("mid_rst_busy",  32'(if1.busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        n_reset1 = 1'b1;
        strobes = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (if1.ifrdy === 1'b1) strobes++;
            chk("post_rst_rdy", 32'(if1.rdy), 32'd1);
        end
        chk("post_rst_strobes", 32'(strobes), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_fb_burst_responder
